// File: rtl/vga_timing_gen.sv
// Combined horizontal/vertical raster timing generator with programmable porches,
// sync polarity and a pixel advance enable; all outputs are registered together.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned H_W      = 10,
    parameter int unsigned V_W      = 9
) (
    input  logic           pxclk_i,
    input  logic           rst_i,
    input  logic           en_i,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o,
    output logic [H_W-1:0] col_o,
    output logic [V_W-1:0] row_o,
    output logic           line_o,
    output logic           frame_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ONE    = H_W'(1);
    localparam logic [H_W-1:0] H_DE_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SY_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SY_END = H_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ONE    = V_W'(1);
    localparam logic [V_W-1:0] V_DE_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SY_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SY_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] col_q, col_d;
    logic [V_W-1:0] row_q, row_d;
    logic           de_q, de_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           line_q, line_d;
    logic           frame_q, frame_d;
    logic           h_sync_win, v_sync_win;

    // Next position; qualifiers below decode this same position so they land
    // on the edge that moves the counters, with no extra stage.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en_i) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + V_ONE;
            end else begin
                col_d = col_q + H_ONE;
            end
        end
    end

    always_comb begin
        h_sync_win = (col_d >= H_SY_BEG) && (col_d < H_SY_END);
        v_sync_win = (row_d >= V_SY_BEG) && (row_d < V_SY_END);
        de_d       = (col_d < H_DE_END) && (row_d < V_DE_END);
        hsync_d    = h_sync_win ? H_POL : ~H_POL;
        vsync_d    = v_sync_win ? V_POL : ~V_POL;
        line_d     = en_i && (col_d == '0);
        frame_d    = line_d && (row_d == '0);
    end

    // Reset parks the raster on the last pixel of the frame, inside both back
    // porches, so the first enabled edge lands on (0,0).
    always_ff @(posedge pxclk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q   <= H_LAST;
            row_q   <= V_LAST;
            de_q    <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign col_o   = col_q;
    assign row_o   = row_q;
    assign de_o    = de_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign line_o  = line_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: raster position is modelled as a linear pixel index, expected
// outputs are queued per edge and popped by a monitor after each rising edge.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int col, row;
        bit de, hs, vs, line, frame;
    } exp_t;

    localparam cfg_t CFG_A = '{480, 2, 41, 2, 272, 2, 10, 2, 1'b0, 1'b0};
    localparam cfg_t CFG_B = '{16, 1, 2, 1, 6, 1, 2, 1, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA, enA, hsA, vsA, deA, lnA, frA;
    logic [9:0] colA;
    logic [8:0] rowA;
    logic       rstB, enB, hsB, vsB, deB, lnB, frB;
    logic [4:0] colB;
    logic [3:0] rowB;

    vga_timing_gen dut_a (
        .pxclk_i(clk), .rst_i(rstA), .en_i(enA),
        .hsync_o(hsA), .vsync_o(vsA), .de_o(deA),
        .col_o(colA), .row_o(rowA), .line_o(lnA), .frame_o(frA)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .H_W(5), .V_W(4)
    ) dut_b (
        .pxclk_i(clk), .rst_i(rstB), .en_i(enB),
        .hsync_o(hsB), .vsync_o(vsB), .de_o(deB),
        .col_o(colB), .row_o(rowB), .line_o(lnB), .frame_o(frB)
    );

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int pA, pB;
    int totA, totB;
    bit cntB = 1'b0;
    int deCnt = 0, vsCnt = 0, hsCnt = 0, frCnt = 0;

    function automatic int total(cfg_t c);
        return (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
    endfunction

    // Expected outputs for linear pixel index p reached on an edge with enable en.
    function automatic exp_t model(cfg_t c, int p, bit en);
        exp_t e;
        int ht = c.ha + c.hfp + c.hs + c.hbp;
        e.col   = p % ht;
        e.row   = p / ht;
        e.de    = (e.col < c.ha) && (e.row < c.va);
        e.hs    = (e.col >= c.ha + c.hfp && e.col < c.ha + c.hfp + c.hs) ? c.hp : !c.hp;
        e.vs    = (e.row >= c.va + c.vfp && e.row < c.va + c.vfp + c.vs) ? c.vp : !c.vp;
        e.line  = en && (e.col == 0);
        e.frame = en && (p == 0);
        return e;
    endfunction

    task automatic cmp(string nm, exp_t e, int col, int row, bit de, bit hs, bit vs, bit ln, bit fr);
        checks++;
        if (col != e.col || row != e.row || de != e.de || hs != e.hs || vs != e.vs
            || ln != e.line || fr != e.frame) begin
            errors++;
            $display("FAIL %s got col=%0d row=%0d de=%0b hs=%0b vs=%0b line=%0b frame=%0b exp col=%0d row=%0d de=%0b hs=%0b vs=%0b line=%0b frame=%0b",
                     nm, col, row, de, hs, vs, ln, fr,
                     e.col, e.row, e.de, e.hs, e.vs, e.line, e.frame);
        end
    endtask

    task automatic cmp_int(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic step_a(bit en);
        @(negedge clk);
        enA = en;
        if (en) pA = (pA + 1) % totA;
        qa.push_back(model(CFG_A, pA, en));
    endtask

    task automatic step_b(bit en);
        @(negedge clk);
        enB = en;
        if (en) pB = (pB + 1) % totB;
        qb.push_back(model(CFG_B, pB, en));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            cmp("A_scoreboard", e, int'(colA), int'(rowA), deA, hsA, vsA, lnA, frA);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qb.size() != 0) begin
            e = qb.pop_front();
            cmp("B_scoreboard", e, int'(colB), int'(rowB), deB, hsB, vsB, lnB, frB);
        end
        if (cntB) begin
            deCnt += int'(deB);
            vsCnt += int'(vsB == 1'b1);
            hsCnt += int'(hsB == 1'b1);
            frCnt += int'(frB);
        end
    end

    initial begin
        totA = total(CFG_A);
        totB = total(CFG_B);
        rstA = 1'b1; enA = 1'b0;
        rstB = 1'b1; enB = 1'b0;
        pA = totA - 1;
        pB = totB - 1;
        repeat (3) @(negedge clk);
        cmp("A_reset", model(CFG_A, pA, 1'b0), int'(colA), int'(rowA), deA, hsA, vsA, lnA, frA);
        cmp("B_reset", model(CFG_B, pB, 1'b0), int'(colB), int'(rowB), deB, hsB, vsB, lnB, frB);

        // Default timing: first edge, two full rows, then random enable.
        rstA = 1'b0;
        step_a(1'b1);
        repeat (2 * 525) step_a(1'b1);
        repeat (400) step_a($urandom_range(0, 3) != 0);

        // Run to (200,100) then reset asynchronously between edges.
        while (pA != 100 * 525 + 200) step_a(1'b1);
        @(posedge clk);
        #3 rstA = 1'b1;
        #1 pA = totA - 1;
        cmp("A_async_rst", model(CFG_A, pA, 1'b0), int'(colA), int'(rowA), deA, hsA, vsA, lnA, frA);
        enA = 1'b0;
        repeat (2) @(negedge clk);
        rstA = 1'b0;
        step_a(1'b1);
        repeat (40) step_a($urandom_range(0, 1) != 0);

        // Small positive-polarity timing: one whole frame of aggregate counts.
        @(negedge clk);
        rstB = 1'b0;
        step_b(1'b1);
        @(posedge clk);
        #2 cntB = 1'b1;
        repeat (totB) step_b(1'b1);
        @(posedge clk);
        #2 cntB = 1'b0;
        cmp_int("B_de_per_frame", deCnt, 16 * 6);
        cmp_int("B_vsync_per_frame", vsCnt, 2 * 20);
        cmp_int("B_hsync_per_frame", hsCnt, 2 * 10);
        cmp_int("B_frames_per_frame", frCnt, 1);

        // Enable pattern 1,0,0,1 across the last pixel of the frame.
        while (pB != totB - 2) step_b(1'b1);
        step_b(1'b1);
        step_b(1'b0);
        step_b(1'b0);
        step_b(1'b1);
        step_b(1'b1);
        repeat (300) step_b($urandom_range(0, 2) != 0);

        @(posedge clk);
        #3;
        cmp_int("queues_drained", qa.size() + qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the single-axis horizontal counter: one block generates both horizontal and vertical VGA/LCD timing.
- Produces hsync, vsync, data-enable, pixel column/row and line/frame strobes, all mutually aligned.
- Sits between the pixel-clock source and the pixel/framebuffer pipeline.
- Adds programmable porches, sync polarity, a pixel-clock enable for divided rates, and a defined reset state.

Parameters:
- H_ACTIVE, 480, visible columns
- H_FP, 2, horizontal front porch, pixels
- H_SYNC, 41, hsync width, pixels
- H_BP, 2, horizontal back porch, pixels (must be ≥1)
- V_ACTIVE, 272, visible rows
- V_FP, 2, vertical front porch, lines
- V_SYNC, 10, vsync width, lines
- V_BP, 2, vertical back porch, lines (must be ≥1)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- H_W, 10, column counter width; must hold H_TOTAL-1
- V_W, 9, row counter width; must hold V_TOTAL-1

Ports:
- pxclk_i  in  1  pixel clock
- rst_i  in  1  asynchronous reset, active-high
- en_i  in  1  pixel advance enable; tie to 1 for full rate
- hsync_o  out  1  horizontal sync, polarity per H_POL
- vsync_o  out  1  vertical sync, polarity per V_POL
- de_o  out  1  high when (col_o, row_o) is in the active area
- col_o  out  H_W  current column, 0..H_TOTAL-1
- row_o  out  V_W  current row, 0..V_TOTAL-1
- line_o  out  1  one-clock strobe on entering column 0
- frame_o  out  1  one-clock strobe on entering (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 525); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 286).
- Order along each axis: active, front porch, sync, back porch.
- Reset (async, while rst_i=1):
  - col_o = H_TOTAL-1, row_o = V_TOTAL-1
  - de_o=0, hsync_o=~H_POL, vsync_o=~V_POL, line_o=0, frame_o=0
  - This position lies in both back porches, so all outputs are consistent with it.
- Advance: on each pxclk_i rising edge with en_i=1:
  - col_o increments; at H_TOTAL-1 it wraps to 0 and row_o advances.
  - row_o increments; at V_TOTAL-1 it wraps to 0.
  - The first enabled edge after reset release yields (0,0) with frame_o=line_o=1.
- Alignment: de_o, hsync_o and vsync_o are registered decodes of the next position, updated on the same edge as col_o/row_o. There is zero skew between position and qualifiers; there is no extra pipeline stage.
- de_o = (col_o < H_ACTIVE) & (row_o < V_ACTIVE).
- hsync_o asserted iff H_ACTIVE+H_FP ≤ col_o ≤ H_ACTIVE+H_FP+H_SYNC-1; default cols 482..522.
- vsync_o asserted iff V_ACTIVE+V_FP ≤ row_o ≤ V_ACTIVE+V_FP+V_SYNC-1; default rows 274..283. Transitions coincide with col_o=0.
- line_o: registered as en_i & (next col == 0). High for exactly one clock even if en_i then drops.
- frame_o: same rule as line_o with next position == (0,0). frame_o implies line_o.
- en_i=0: col_o, row_o, de_o, hsync_o and vsync_o hold; line_o and frame_o deassert on that edge.
- Reset mid-frame: immediate return to the reset state; the next frame starts cleanly at (0,0).
- All comparisons are unsigned at full counter width. Counters never exceed their totals.
- No combinational input-to-output paths.

Test Plan:
- Reset then release, en_i=1, defaults -> first edge: col=0, row=0, de=1, frame=1, line=1, hsync=1, vsync=1.
- Row 0 sweep -> de falls at col 480; hsync=0 for cols 482..522 (41 clocks); col wraps 524->0 with row 0->1 and line=1.
- Full frame -> frame_o period is 150150 clocks; vsync=0 exactly on rows 274..283 (10×525 clocks); de high for 480×272 = 130560 clocks per frame.
- en_i toggled 1,0,0,1 across col 524 of row 285 -> outputs hold during en=0; the wrap to (0,0) happens on the re-enable edge; frame_o is high for one clock only.
- H_POL=1, V_POL=1, H_ACTIVE=16, H_FP=1, H_SYNC=2, H_BP=1 -> reset hsync=0; hsync=1 on cols 17..18; H_TOTAL=20.
- Assert rst_i asynchronously mid-line (col 200, row 100) -> outputs go to the reset values without a clock edge; after release, the next frame_o arrives on the first enabled edge.
